// File: rtl/ha1588_reg_arb_if.sv
// ha1588_reg_arb_if: per-master command/response bundle for the ha1588 register arbiter
interface ha1588_reg_arb_if;
  logic        req;
  logic        wr;
  logic        lock;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, wr, lock, addr, wdata, input ack, rvalid, rdata);
  modport slave  (input req, wr, lock, addr, wdata, output ack, rvalid, rdata);
endinterface

// File: rtl/ha1588_reg_arb.sv
// ha1588_reg_arb: round-robin two-master arbiter with lock and lock timeout for the ha1588 register port
module ha1588_reg_arb #(
  parameter int RD_LATENCY   = 1,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  ha1588_reg_arb_if.slave   m0,
  ha1588_reg_arb_if.slave   m1,
  output logic              lock_err_o,
  output logic              reg_wr_o,
  output logic              reg_rd_o,
  output logic [7:0]        reg_addr_o,
  output logic [31:0]       reg_wdata_o,
  input  logic [31:0]       reg_rdata_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_e;
  state_e      state_q, state_d;
  logic        last_q, last_d, glock_q, glock_d, lock_q, lock_d, owner_q, owner_d;
  logic        lock_err_q, lock_err_d, reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d;
  logic [1:0]  ack_q, ack_d, rvalid_q, rvalid_d, rcnt_q, rcnt_d;
  logic [15:0] lcnt_q, lcnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]  req, elig;
  logic        idle, issue, done, go, sel, owner_req, tmo;
  assign req       = {m1.req, m0.req};
  assign idle      = state_q == IDLE;
  assign issue     = state_q == ISSUE;
  assign done      = state_q == RDWAIT && rcnt_q == 2'd0;
  assign owner_req = owner_q ? m1.req : m0.req;
  assign elig      = lock_q ? req & (owner_q ? 2'b10 : 2'b01) : req;
  // a grant is held off in the lock_err cycle so release and re-arbitration never coincide
  assign go        = idle && |elig && !lock_err_q;
  assign sel       = &elig ? ~last_q : elig[1];
  assign tmo       = idle && lock_q && !owner_req && lcnt_q == 16'(LOCK_TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      glock_q    <= 1'b0;
      lock_q     <= 1'b0;
      owner_q    <= 1'b0;
      lock_err_q <= 1'b0;
      reg_wr_q   <= 1'b0;
      reg_rd_q   <= 1'b0;
      ack_q      <= 2'b00;
      rvalid_q   <= 2'b00;
      rcnt_q     <= 2'd0;
      lcnt_q     <= 16'd0;
      addr_q     <= 8'd0;
      wdata_q    <= 32'd0;
      rdata0_q   <= 32'd0;
      rdata1_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      glock_q    <= glock_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      lock_err_q <= lock_err_d;
      reg_wr_q   <= reg_wr_d;
      reg_rd_q   <= reg_rd_d;
      ack_q      <= ack_d;
      rvalid_q   <= rvalid_d;
      rcnt_q     <= rcnt_d;
      lcnt_q     <= lcnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end
  always_comb begin
    state_d = idle ? (go ? ISSUE : IDLE) : issue ? (reg_rd_q ? RDWAIT : IDLE) : (done ? IDLE : RDWAIT);
  end
  always_comb begin
    last_d     = go ? sel : last_q;
    glock_d    = go ? (sel ? m1.lock : m0.lock) : glock_q;
    ack_d      = go ? (sel ? 2'b10 : 2'b01) : 2'b00;
    reg_wr_d   = go && (sel ? m1.wr : m0.wr);
    reg_rd_d   = go && !(sel ? m1.wr : m0.wr);
    addr_d     = go ? (sel ? m1.addr : m0.addr) : addr_q;
    wdata_d    = go ? (sel ? m1.wdata : m0.wdata) : wdata_q;
    lock_d     = issue ? glock_q : tmo ? 1'b0 : lock_q;
    owner_d    = issue ? last_q : owner_q;
    lcnt_d     = idle && lock_q && !owner_req && !tmo ? lcnt_q + 16'd1 : 16'd0;
    lock_err_d = tmo;
    rcnt_d     = issue ? 2'(RD_LATENCY - 1) : rcnt_q == 2'd0 ? 2'd0 : rcnt_q - 2'd1;
    rvalid_d   = done ? (last_q ? 2'b10 : 2'b01) : 2'b00;
    rdata0_d   = done && !last_q ? reg_rdata_i : rdata0_q;
    rdata1_d   = done && last_q ? reg_rdata_i : rdata1_q;
  end
  assign m0.ack      = ack_q[0];
  assign m1.ack      = ack_q[1];
  assign m0.rvalid   = rvalid_q[0];
  assign m1.rvalid   = rvalid_q[1];
  assign m0.rdata    = rdata0_q;
  assign m1.rdata    = rdata1_q;
  assign lock_err_o  = lock_err_q;
  assign reg_wr_o    = reg_wr_q;
  assign reg_rd_o    = reg_rd_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
endmodule

// File: tb/tb_ha1588_reg_arb.sv
// tb_ha1588_reg_arb: directed checks of ha1588_reg_arb with a 3-cycle-latency core read model
module tb_ha1588_reg_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        lock_err, reg_wr, reg_rd;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [2:0]  rd_pipe = 3'b000;
  logic [7:0]  a0, a1, a2;
  int          n_chk = 0;
  int          n_fail = 0;
  ha1588_reg_arb_if m0();
  ha1588_reg_arb_if m1();
  ha1588_reg_arb #(.RD_LATENCY(3), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .m0(m0), .m1(m1),
    .lock_err_o(lock_err), .reg_wr_o(reg_wr), .reg_rd_o(reg_rd),
    .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_rdata_i(reg_rdata)
  );
  always #5 clk = ~clk;
  // core model: read data appears exactly 3 cycles after reg_rd, zero otherwise
  always @(posedge clk) begin
    rd_pipe <= {rd_pipe[1:0], reg_rd};
    a0 <= reg_addr;
    a1 <= a0;
    a2 <= a1;
  end
  assign reg_rdata = rd_pipe[2] ? (a2 == 8'h20 ? 32'h12345678 : {4{a2}}) : 32'h0;
  task automatic test_reset;
    rst = 1'b1;
    m0.req = 0; m0.wr = 0; m0.lock = 0; m0.addr = 0; m0.wdata = 0;
    m1.req = 0; m1.wr = 0; m1.lock = 0; m1.addr = 0; m1.wdata = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({m0.ack, m1.ack, m0.rvalid, m1.rvalid, lock_err, reg_wr, reg_rd, reg_addr, reg_wdata, m0.rdata, m1.rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got ack=%b%b rv=%b%b le=%b wr=%b rd=%b addr=%h wdata=%h, required all 0",
               m0.ack, m1.ack, m0.rvalid, m1.rvalid, lock_err, reg_wr, reg_rd, reg_addr, reg_wdata);
    end
    rst = 1'b0;
  endtask
  task automatic test_write;
    m0.req = 1; m0.wr = 1; m0.lock = 0; m0.addr = 8'h10; m0.wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_chk++;
    if ({m0.ack, m1.ack, reg_wr, reg_rd, reg_addr, reg_wdata, m0.rvalid, m1.rvalid, lock_err} !== {4'b1010, 8'h10, 32'hDEADBEEF, 3'b000}) begin
      n_fail++;
      $display("FAIL write_issue got ack=%b%b wr=%b rd=%b addr=%h wdata=%h, required ack=10 wr=1 rd=0 addr=10 wdata=deadbeef",
               m0.ack, m1.ack, reg_wr, reg_rd, reg_addr, reg_wdata);
    end
    m0.req = 0;
    @(negedge clk);
    n_chk++;
    if ({m0.ack, m1.ack, reg_wr, reg_rd} !== 4'b0000) begin
      n_fail++;
      $display("FAIL write_strobe_end got ack=%b%b wr=%b rd=%b, required all 0", m0.ack, m1.ack, reg_wr, reg_rd);
    end
    n_chk++;
    if ({reg_addr, reg_wdata} !== {8'h10, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL write_hold got addr=%h wdata=%h, required 10 deadbeef", reg_addr, reg_wdata);
    end
  endtask
  task automatic test_read;
    m1.req = 1; m1.wr = 0; m1.lock = 0; m1.addr = 8'h20;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_chk++;
        if ({m1.ack, m0.ack, reg_rd, reg_wr, reg_addr} !== {4'b1010, 8'h20}) begin
          n_fail++;
          $display("FAIL read_issue got ack1=%b ack0=%b rd=%b wr=%b addr=%h, required 1 0 1 0 20", m1.ack, m0.ack, reg_rd, reg_wr, reg_addr);
        end
        m1.req = 0;
      end
      n_chk++;
      if ({m1.rvalid, m0.rvalid} !== {(k == 5), 1'b0}) begin
        n_fail++;
        $display("FAIL read_rvalid cycle %0d got rv1=%b rv0=%b, required rv1=%b rv0=0", k, m1.rvalid, m0.rvalid, (k == 5));
      end
      if (k == 5) begin
        n_chk++;
        if (m1.rdata !== 32'h12345678) begin
          n_fail++;
          $display("FAIL read_rdata got %h, required 12345678", m1.rdata);
        end
      end
    end
  endtask
  task automatic test_round_robin;
    m0.req = 1; m0.wr = 1; m0.lock = 0; m0.addr = 8'h40; m0.wdata = 32'hA0A0A0A0;
    m1.req = 1; m1.wr = 1; m1.lock = 0; m1.addr = 8'h41; m1.wdata = 32'hB1B1B1B1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_chk++;
      if ({m0.ack, m1.ack} !== {(k % 4 == 1), (k % 4 == 3)}) begin
        n_fail++;
        $display("FAIL rr_ack cycle %0d got ack0=%b ack1=%b, required %b %b", k, m0.ack, m1.ack, (k % 4 == 1), (k % 4 == 3));
      end
      if (k % 2 == 1) begin
        n_chk++;
        if (reg_addr !== (k % 4 == 1 ? 8'h40 : 8'h41)) begin
          n_fail++;
          $display("FAIL rr_addr cycle %0d got %h, required %h", k, reg_addr, (k % 4 == 1 ? 8'h40 : 8'h41));
        end
      end
    end
    m0.req = 0; m1.req = 0;
  endtask
  task automatic test_lock;
    m1.req = 1; m1.wr = 1; m1.lock = 1; m1.addr = 8'h50; m1.wdata = 32'h5;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_chk++;
      if ({m1.ack, m0.ack} !== {(k == 1 || k == 3 || k == 5), (k == 7)}) begin
        n_fail++;
        $display("FAIL lock_ack cycle %0d got ack1=%b ack0=%b, required %b %b", k, m1.ack, m0.ack, (k == 1 || k == 3 || k == 5), (k == 7));
      end
      if (k == 1) begin
        m0.req = 1; m0.wr = 1; m0.lock = 0; m0.addr = 8'h60;
        m1.addr = 8'h51;
      end
      if (k == 3) begin m1.lock = 0; m1.addr = 8'h52; end
      if (k == 5) m1.req = 0;
      if (k == 7) m0.req = 0;
    end
  endtask
  task automatic test_timeout;
    int first_ack = 0;
    m1.req = 1; m1.wr = 1; m1.lock = 1; m1.addr = 8'h70;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_chk++;
        if (m1.ack !== 1'b1) begin
          n_fail++;
          $display("FAIL timeout_lock_grant got ack1=%b, required 1", m1.ack);
        end
        m1.req = 0; m1.lock = 0;
        m0.req = 1; m0.wr = 1; m0.lock = 0; m0.addr = 8'h71;
      end
      n_chk++;
      if (lock_err !== (k == 10)) begin
        n_fail++;
        $display("FAIL timeout_lock_err cycle %0d got %b, required %b", k, lock_err, (k == 10));
      end
      if (m0.ack === 1'b1 && first_ack == 0) begin
        first_ack = k;
        m0.req = 0;
      end
    end
    n_chk++;
    if (first_ack < 11 || first_ack > 12) begin
      n_fail++;
      $display("FAIL timeout_m0_ack got cycle %0d (0 = none), required 11 or 12", first_ack);
    end
    m0.req = 0;
  endtask
  task automatic test_reset_rdwait;
    m0.req = 1; m0.wr = 0; m0.lock = 0; m0.addr = 8'h33;
    @(negedge clk);
    n_chk++;
    if ({m0.ack, reg_rd} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_read_issue got ack0=%b rd=%b, required 1 1", m0.ack, reg_rd);
    end
    m0.req = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    n_chk++;
    if ({m0.ack, m1.ack, m0.rvalid, m1.rvalid, lock_err, reg_wr, reg_rd, reg_addr, reg_wdata, m0.rdata, m1.rdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_outputs got ack=%b%b rv=%b%b le=%b wr=%b rd=%b addr=%h wdata=%h rd0=%h rd1=%h, required all 0",
               m0.ack, m1.ack, m0.rvalid, m1.rvalid, lock_err, reg_wr, reg_rd, reg_addr, reg_wdata, m0.rdata, m1.rdata);
    end
    rst = 0;
    for (int k = 4; k <= 7; k++) begin
      @(negedge clk);
      n_chk++;
      if ({m0.rvalid, m1.rvalid} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_no_rvalid cycle %0d got rv0=%b rv1=%b, required 0 0", k, m0.rvalid, m1.rvalid);
      end
    end
    m0.req = 1; m0.wr = 1; m0.addr = 8'h80;
    m1.req = 1; m1.wr = 1; m1.lock = 0; m1.addr = 8'h81;
    @(negedge clk);
    n_chk++;
    if ({m0.ack, m1.ack} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_first_tie got ack0=%b ack1=%b, required 1 0", m0.ack, m1.ack);
    end
    m0.req = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({m0.ack, m1.ack} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_second_grant got ack0=%b ack1=%b, required 0 1", m0.ack, m1.ack);
    end
    m1.req = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_write;
    test_read;
    test_round_robin;
    test_lock;
    test_timeout;
    test_reset_rdwait;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ha1588_reg_arb.md
# ha1588_reg_arb

Two-master arbiter for the single ha1588 register port (reg_wr/reg_rd/reg_addr/reg_wdata/reg_rdata). It shares the port between master 0 (host CPU bridge) and master 1 (hardware PTP servo) with round-robin arbitration. A lock lets one master run atomic multi-register sequences, such as a coherent RTC period/adjust update or a timestamp-queue drain. It sits between the bus bridges and the ha1588 core, all on the register clock.

## Interface
- RD_LATENCY, 1: clk cycles from reg_rd high to reg_rdata valid; legal range 1..4.
- LOCK_TIMEOUT, 255: idle cycles a lock owner may hold the lock without requesting before forced release; range 1..65535.

Clocking: one clock; reset is synchronous and active-high.

- clk  in  1  register clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  command request; hold until ack
- m0_wr, m1_wr  in  1  1 = write, 0 = read
- m0_lock, m1_lock  in  1  keep grant after this command
- m0_addr, m1_addr  in  8  register address
- m0_wdata, m1_wdata  in  32  write data
- m0_ack, m1_ack  out  1  one-cycle pulse: command issued to core
- m0_rvalid, m1_rvalid  out  1  one-cycle pulse: read data valid
- m0_rdata, m1_rdata  out  32  read data, valid with rvalid
- lock_err  out  1  one-cycle pulse: lock forcibly released by timeout
- reg_wr, reg_rd  out  1  core write/read strobe, one cycle
- reg_addr  out  8  core address
- reg_wdata  out  32  core write data
- reg_rdata  in  32  core read data

## Operation
- States: IDLE, ISSUE, RDWAIT.
- IDLE: requests are sampled only here.
  - Eligible = all requesting masters, or only the owner while a lock is held.
  - Tie with no lock: grant the master not granted last. last_grant resets to 1, so m0 wins the first tie.
  - On a grant: register reg_addr/reg_wdata, reg_wr or reg_rd, and that master's ack. Go to ISSUE.
- ISSUE (one cycle): strobes and ack are high.
  - Record lock state: owner = granted master if its lock = 1; otherwise the lock is cleared.
  - Write → IDLE. Read → RDWAIT, counter loaded with RD_LATENCY−1.
- RDWAIT: count down.
  - At 0, capture reg_rdata into mX_rdata and pulse mX_rvalid on the next cycle.
  - The state is IDLE in that rvalid cycle.
- Only one command is outstanding at a time. No issue occurs during ISSUE or RDWAIT.
- Lock timeout:
  - A 16-bit counter runs in IDLE while a lock is held and the owner's req = 0.
  - The counter is cleared whenever the owner requests.
  - When count reaches LOCK_TIMEOUT: clear the lock, pulse lock_err for one cycle, and arbitrate normally from the next cycle.
- The non-owner's request stays pending, with no ack, while locked. It is not dropped.
- A master dropping req before ack: the command is not issued if req is low when IDLE samples. No error.
- Address and data are passed unmodified. reg_addr/reg_wdata hold their last value when idle.
- rst in any state:
  - State → IDLE; lock, counters and last_grant (=1) are cleared.
  - A pending read is discarded, with no rvalid.
  - All outputs go to 0 on the next edge.

## Timing
- Reset values: every output = 0 (acks, rvalids, rdata, lock_err, reg_wr, reg_rd, reg_addr, reg_wdata).
- Write: req sampled in IDLE at cycle N. reg_wr and ack are high at N+1. IDLE at N+2. Next issue is no earlier than N+3 (one write per 2 cycles).
- Read: req at N → reg_rd and ack at N+1 → reg_rdata sampled at N+1+RD_LATENCY → rvalid/rdata at N+2+RD_LATENCY. Next issue is no earlier than N+3+RD_LATENCY.
- A master may change req/addr/wdata from the cycle after ack.
- Lock release: the owner's ISSUE with lock = 0 frees the port. The other master can be granted in the next IDLE.
- lock_err and the first post-timeout grant decision do not occur in the same cycle.

## Test plan
- Reset, then m0 writes addr 0x10, data 0xDEADBEEF → reg_wr and m0_ack high at cycle 1 with reg_addr=0x10 and reg_wdata=0xDEADBEEF. Nothing else toggles.
- RD_LATENCY=3: m1 reads 0x20 while the core model drives 0x12345678 three cycles after reg_rd → m1_rvalid=1 and m1_rdata=0x12345678 exactly 5 cycles after req is sampled. m0_rvalid stays 0.
- m0 and m1 both request continuously (writes) → acks alternate m0, m1, m0, m1 with 2-cycle spacing.
- m1 issues 3 writes with lock=1, 1, 0 while m0 requests throughout → m1 gets 3 consecutive acks before m0's first ack.
- LOCK_TIMEOUT=8: m1 takes a lock and then idles with m0 requesting → lock_err pulses once after 8 idle cycles. m0 is acked within 2 cycles after that.
- rst asserted during RDWAIT → no rvalid follows. All outputs are 0 the cycle after rst. The first post-reset tie grants m0.
